// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, 1-cycle imem fetch, single-entry skid buffer and IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid
);
  typedef enum logic [1:0] {FETCH, STALL_EMPTY, STALL_FULL} state_t;
  state_t state, state_next;
  logic [31:0] pc, resp_pc, skid_instr, skid_pc, target;
  logic        resp_v;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_addr = pc;
  always_comb begin
    imem_en    = ~rst & ~redirect & ~stall;
    state_next = (redirect | ~stall) ? FETCH
               : state == FETCH ? (resp_v ? STALL_FULL : STALL_EMPTY) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      resp_v     <= 1'b0;
      resp_pc    <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      id_instr   <= NOP_INSTR;
      id_pc      <= RESET_PC;
      id_valid   <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc       <= target;
        resp_v   <= 1'b0;
        id_instr <= NOP_INSTR;
        id_pc    <= target;
        id_valid <= 1'b0;
      end else if (stall) begin
        resp_v <= 1'b0;
        // Only a response in flight when the stall first hits needs parking.
        if (state == FETCH && resp_v) begin
          skid_instr <= imem_rdata;
          skid_pc    <= resp_pc;
        end
      end else begin
        pc       <= pc + 32'd4;
        resp_v   <= 1'b1;
        resp_pc  <= pc;
        id_instr <= state == STALL_FULL ? skid_instr
                  : (state == FETCH && resp_v) ? imem_rdata : NOP_INSTR;
        id_valid <= state == STALL_FULL || (state == FETCH && resp_v);
        id_pc    <= state == STALL_FULL ? skid_pc : state == FETCH ? resp_pc : id_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a synchronous memory returning 0xA000_0000|addr.
module tb_fetch_stage;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_en, id_valid, w_en, w_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (imem_en) imem_rdata <= 32'hA000_0000 | imem_addr;
  always_ff @(posedge clk) if (w_en) w_rdata <= 32'hA000_0000 | w_addr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid));

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_en(w_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .id_instr(w_instr), .id_pc(w_pc), .id_valid(w_valid));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h0, 32'h13}) begin errors++; $display("FAIL reset_out got %b %h %h exp 0 00000000 00000013", id_valid, id_pc, id_instr); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    vectors++; if ({w_valid, w_pc, w_instr} !== {1'b0, 32'hFFFF_FFF8, 32'h13}) begin errors++; $display("FAIL reset_w got %b %h %h exp 0 fffffff8 00000013", w_valid, w_pc, w_instr); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (imem_en !== 1'b1) begin errors++; $display("FAIL reset_en got %b exp 1", imem_en); end
    step();
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_valid got %b exp 0", id_valid); end
  endtask

  task automatic test_startup;
    logic [31:0] e, w;
    for (int i = 0; i < 3; i++) begin
      step();
      e = 32'(4 * i);
      w = 32'hFFFF_FFF8 + 32'(4 * i);
      vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, e, 32'hA000_0000 | e}) begin errors++; $display("FAIL startup[%0d] got %b %h %h exp 1 %h %h", i, id_valid, id_pc, id_instr, e, 32'hA000_0000 | e); end
      vectors++; if ({w_valid, w_pc, w_instr} !== {1'b1, w, 32'hA000_0000 | w}) begin errors++; $display("FAIL wrap[%0d] got %b %h %h exp 1 %h %h", i, w_valid, w_pc, w_instr, w, 32'hA000_0000 | w); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    vectors++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_en got %b exp 0", imem_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({id_valid, id_pc, imem_en} !== {1'b1, 32'h8, 1'b0}) begin errors++; $display("FAIL stall_hold[%0d] got %b %h en=%b exp 1 00000008 en=0", i, id_valid, id_pc, imem_en); end
    end
    stall = 1'b0;
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'hC, 32'hA000_000C}) begin errors++; $display("FAIL stall_rel0 got %b %h %h exp 1 0000000c a000000c", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h10, 32'hA000_0010}) begin errors++; $display("FAIL stall_rel1 got %b %h %h exp 1 00000010 a0000010", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_redirect;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    vectors++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_en got %b exp 0", imem_en); end
    step();
    redirect = 1'b0;
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h100, 32'h13}) begin errors++; $display("FAIL redir_flush got %b %h %h exp 0 00000100 00000013", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, id_instr} !== {1'b0, 32'h13}) begin errors++; $display("FAIL redir_gap got %b %h exp 0 00000013", id_valid, id_instr); end
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h100, 32'hA000_0100}) begin errors++; $display("FAIL redir_target got %b %h %h exp 1 00000100 a0000100", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h104, 32'hA000_0104}) begin errors++; $display("FAIL redir_next got %b %h %h exp 1 00000104 a0000104", id_valid, id_pc, id_instr); end
  endtask

  task automatic test_redirect_stall;
    stall = 1'b1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0202;
    step();
    redirect = 1'b0;
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h200, 32'h13}) begin errors++; $display("FAIL rs_flush got %b %h %h exp 0 00000200 00000013", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, imem_en} !== 2'b00) begin errors++; $display("FAIL rs_hold got valid=%b en=%b exp 0 0", id_valid, imem_en); end
    stall = 1'b0;
    #1;
    vectors++; if ({imem_en, imem_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rs_refetch got en=%b %h exp 1 00000200", imem_en, imem_addr); end
    step();
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rs_empty got %b exp 0", id_valid); end
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h200, 32'hA000_0200}) begin errors++; $display("FAIL rs_target got %b %h %h exp 1 00000200 a0000200", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, id_pc} !== {1'b1, 32'h204}) begin errors++; $display("FAIL rs_next got %b %h exp 1 00000204", id_valid, id_pc); end
  endtask

  task automatic test_async_reset;
    stall = 1'b1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    vectors++; if ({id_valid, id_pc, id_instr, imem_addr} !== {1'b0, 32'h0, 32'h13, 32'h0}) begin errors++; $display("FAIL arst_out got %b %h %h addr=%h exp 0 00000000 00000013 addr=00000000", id_valid, id_pc, id_instr, imem_addr); end
    @(posedge clk);
    #1 rst = 1'b0;
    stall = 1'b0;
    step();
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_gap got %b exp 0", id_valid); end
    step();
    vectors++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, 32'hA000_0000}) begin errors++; $display("FAIL arst_first got %b %h %h exp 1 00000000 a0000000", id_valid, id_pc, id_instr); end
    step();
    vectors++; if ({id_valid, id_pc} !== {1'b1, 32'h4}) begin errors++; $display("FAIL arst_next got %b %h exp 1 00000004", id_valid, id_pc); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
